// File: rtl/adc_jesd204_chan_buffer.sv
// Per-channel ADC sample buffer: IDLE/RUN/DRAIN control, FIFO with valid/ready output, sticky overflow.
// Optional ADC_JESD204_CHAN_BUFFER_OVF_COUNT_EN adds a saturating dropped-beat counter (adc_ovf_count).
module adc_jesd204_chan_buffer #(
    parameter int DATA_PATH_WIDTH = 2,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                         adc_clk,
    input  logic                         adc_rstn,
    input  logic                         adc_enable,
    input  logic                         adc_valid,
    input  logic [16*DATA_PATH_WIDTH-1:0] adc_dfmt_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [16*DATA_PATH_WIDTH-1:0] m_data,
    output logic [FIFO_ADDR_WIDTH:0]     fifo_level,
    output logic                         adc_ovf,
    input  logic                         adc_ovf_clr,
    output logic                         busy
`ifdef ADC_JESD204_CHAN_BUFFER_OVF_COUNT_EN
    ,
    output logic [15:0]                  adc_ovf_count
`endif
);

    localparam int DW    = 16 * DATA_PATH_WIDTH;
    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam logic [FIFO_ADDR_WIDTH:0] FULL_LVL = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                     state, state_nxt;
    logic [DW-1:0]              mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                       wr_try, rd_fire, full, wr_en, ovf_evt;

    always_ff @(posedge adc_clk) begin
        if (!adc_rstn) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (adc_enable) state_nxt = RUN;
            RUN:     if (!adc_enable) state_nxt = DRAIN;
            DRAIN: begin
                if (adc_enable)           state_nxt = RUN;
                else if (fifo_level == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign wr_try  = (state == RUN) && adc_enable && adc_valid;
    assign rd_fire = m_valid && m_ready;
    assign full    = (fifo_level == FULL_LVL);
    // When full, the slot being read out this cycle is the one written, so a
    // concurrent transfer frees exactly the space the write needs.
    assign wr_en   = wr_try && (!full || rd_fire);
    assign ovf_evt = wr_try && full && !rd_fire;

    always_ff @(posedge adc_clk) begin
        if (wr_en) mem[wr_ptr] <= adc_dfmt_data;
    end

    always_ff @(posedge adc_clk) begin
        if (!adc_rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en)   wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_fire})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Head of the FIFO is presented directly; gating keeps m_data at 0 when empty.
    assign m_valid = (fifo_level != '0);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge adc_clk) begin
        if (!adc_rstn)        adc_ovf <= 1'b0;
        else if (ovf_evt)     adc_ovf <= 1'b1;
        else if (adc_ovf_clr) adc_ovf <= 1'b0;
    end

`ifdef ADC_JESD204_CHAN_BUFFER_OVF_COUNT_EN
    always_ff @(posedge adc_clk) begin
        if (!adc_rstn) adc_ovf_count <= '0;
        else if (ovf_evt) begin
            if (adc_ovf_clr)                 adc_ovf_count <= 16'd1;
            else if (adc_ovf_count != 16'hFFFF) adc_ovf_count <= adc_ovf_count + 16'd1;
        end else if (adc_ovf_clr) adc_ovf_count <= '0;
    end
`endif

endmodule
